// File: rtl/cmp_result_tracker_if.sv
// Flag inputs and tracked-result outputs of cmp_result_tracker, grouped as one bus.
// CNT_W must match the CNT_W of the attached tracker.
interface cmp_result_tracker_if #(
    parameter int CNT_W = 8
);
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             clr_cnt;
    logic [1:0]       state_code;
    logic             change_pulse;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic             onehot_err;

    modport master (
        output a_gt_b, a_lt_b, a_eq_b, clr_cnt,
        input  state_code, change_pulse, gt_cnt, lt_cnt, eq_cnt, onehot_err
    );

    modport slave (
        input  a_gt_b, a_lt_b, a_eq_b, clr_cnt,
        output state_code, change_pulse, gt_cnt, lt_cnt, eq_cnt, onehot_err
    );
endinterface

// File: rtl/cmp_result_tracker.sv
// Stability filter and entry counters for the 2-bit comparator flags.
// Optional macro CMP_ONEHOT_CHECK_EN builds the sticky onehot_err check.
module cmp_result_tracker #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    cmp_result_tracker_if.slave  bus
);
    localparam logic [7:0] ST_MAX = 8'(STABLE_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]       r_flags_p0;
    logic             r_vld_p0;
    logic [1:0]       r_prev_cand_p1;
    logic [7:0]       r_st_p1;
    logic [1:0]       r_state_p2;
    logic             r_pulse_p2;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [1:0]       w_cand_p0;
    logic [7:0]       w_st_next;
    logic             w_accept;

    // Stage 1 -> 2: candidate code, 00 meaning "not exactly one flag"
    always_comb begin
        w_cand_p0 = 2'b00;
        if (r_vld_p0) begin
            case (r_flags_p0)
                3'b001:  w_cand_p0 = 2'b01;
                3'b100:  w_cand_p0 = 2'b10;
                3'b010:  w_cand_p0 = 2'b11;
                default: w_cand_p0 = 2'b00;
            endcase
        end
    end

    // Stage 2 -> 3: run length of identical candidates and the accept decision
    always_comb begin
        w_st_next = 8'd1;
        if (w_cand_p0 == 2'b00)
            w_st_next = 8'd0;
        else if (w_cand_p0 == r_prev_cand_p1)
            w_st_next = (r_st_p1 >= ST_MAX) ? ST_MAX : r_st_p1 + 8'd1;
        w_accept = (w_cand_p0 != 2'b00) && (w_st_next == ST_MAX) &&
                   (w_cand_p0 != r_state_p2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags_p0     <= 3'b000;
            r_vld_p0       <= 1'b0;
            r_prev_cand_p1 <= 2'b00;
            r_st_p1        <= 8'd0;
            r_state_p2     <= 2'b00;
            r_pulse_p2     <= 1'b0;
            r_gt_cnt       <= '0;
            r_lt_cnt       <= '0;
            r_eq_cnt       <= '0;
        end else begin
            r_flags_p0     <= {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
            r_vld_p0       <= 1'b1;
            r_prev_cand_p1 <= w_cand_p0;
            r_st_p1        <= w_st_next;
            r_pulse_p2     <= w_accept;
            if (w_accept)
                r_state_p2 <= w_cand_p0;
            // Clear beats a coincident accept; the pulse above still fires
            if (bus.clr_cnt) begin
                r_gt_cnt <= '0;
                r_lt_cnt <= '0;
                r_eq_cnt <= '0;
            end else if (w_accept) begin
                case (w_cand_p0)
                    2'b01:   r_eq_cnt <= sat_inc(r_eq_cnt);
                    2'b10:   r_gt_cnt <= sat_inc(r_gt_cnt);
                    2'b11:   r_lt_cnt <= sat_inc(r_lt_cnt);
                    default: ;
                endcase
            end
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    logic r_onehot_err;

    always_ff @(posedge clk) begin
        if (reset || bus.clr_cnt)
            r_onehot_err <= 1'b0;
        else if (r_vld_p0 && (w_cand_p0 == 2'b00))
            r_onehot_err <= 1'b1;
    end

    assign bus.onehot_err = r_onehot_err;
`else
    assign bus.onehot_err = 1'b0;
`endif

    assign bus.state_code   = r_state_p2;
    assign bus.change_pulse = r_pulse_p2;
    assign bus.gt_cnt       = r_gt_cnt;
    assign bus.lt_cnt       = r_lt_cnt;
    assign bus.eq_cnt       = r_eq_cnt;
endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker: a history-based model predicts each
// accepted change; a negedge monitor matches every change_pulse against it.
module tb_cmp_result_tracker;
    localparam int STABLE = 4;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cmp_result_tracker_if #(.CNT_W(CNT_W)) bus ();
    cmp_result_tracker #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         edge_no;
        logic [1:0] code;
        int         gt, lt, eq;
    } exp_t;
    exp_t sbq[$];

    logic [1:0] m_state = 2'b00;
    int         m_gt = 0, m_lt = 0, m_eq = 0;
    bit         m_err = 1'b0;
    logic [2:0] hist[$];

    initial begin
        bus.a_gt_b  = 1'b0;
        bus.a_lt_b  = 1'b0;
        bus.a_eq_b  = 1'b0;
        bus.clr_cnt = 1'b0;
    end

    function automatic logic [1:0] code_of(input logic [2:0] f);
        if ($countones(f) != 1) return 2'b00;
        if (f[2]) return 2'b10;
        if (f[1]) return 2'b11;
        return 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: a result is accepted once the last STABLE registered samples are
    // the same valid code and that code differs from the currently held result.
    task automatic model_edge(input logic [2:0] f, input bit clr, input bit rst, input int edge_no);
        bit         same;
        logic [1:0] c;
        exp_t       e;
        if (rst) begin
            m_state = 2'b00; m_gt = 0; m_lt = 0; m_eq = 0; m_err = 1'b0;
            hist.delete();
            return;
        end
        if (hist.size() == STABLE) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] !== hist[0]) same = 1'b0;
            c = code_of(hist[0]);
            if (same && c != 2'b00 && c != m_state) begin
                m_state = c;
                if (c == 2'b10) m_gt = (m_gt < MAXC) ? m_gt + 1 : MAXC;
                if (c == 2'b11) m_lt = (m_lt < MAXC) ? m_lt + 1 : MAXC;
                if (c == 2'b01) m_eq = (m_eq < MAXC) ? m_eq + 1 : MAXC;
                if (clr) begin m_gt = 0; m_lt = 0; m_eq = 0; end
                e.edge_no = edge_no; e.code = c; e.gt = m_gt; e.lt = m_lt; e.eq = m_eq;
                sbq.push_back(e);
            end
        end
`ifdef CMP_ONEHOT_CHECK_EN
        if (hist.size() > 0 && code_of(hist[hist.size()-1]) == 2'b00) m_err = 1'b1;
`endif
        if (clr) begin m_gt = 0; m_lt = 0; m_eq = 0; m_err = 1'b0; end
        hist.push_back(f);
        if (hist.size() > STABLE) void'(hist.pop_front());
    endtask

    // One clock of stimulus: check the outputs of the last edge, then drive the next.
    task automatic step(input logic [2:0] f, input bit clr = 1'b0, input bit rst = 1'b0);
        @(negedge clk);
        #1;
        chk("state_code", 32'(bus.state_code), 32'(m_state));
        chk("onehot_err", 32'(bus.onehot_err), 32'(m_err));
        chk("gt_cnt", 32'(bus.gt_cnt), 32'(m_gt));
        chk("lt_cnt", 32'(bus.lt_cnt), 32'(m_lt));
        chk("eq_cnt", 32'(bus.eq_cnt), 32'(m_eq));
        {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = f;
        bus.clr_cnt = clr;
        reset = rst;
        model_edge(f, clr, rst, edge_cnt + 1);
    endtask

    task automatic hold(input logic [2:0] f, input int n);
        for (int i = 0; i < n; i++) step(f);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.change_pulse === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at edge %0d state_code=%0d, no change expected",
                         edge_cnt, bus.state_code);
            end else begin
                e = sbq.pop_front();
                if (e.edge_no != edge_cnt || bus.state_code !== e.code ||
                    bus.gt_cnt !== CNT_W'(e.gt) || bus.lt_cnt !== CNT_W'(e.lt) ||
                    bus.eq_cnt !== CNT_W'(e.eq)) begin
                    errors++;
                    $display("FAIL pulse actual edge=%0d code=%0d gt=%0d lt=%0d eq=%0d expected edge=%0d code=%0d gt=%0d lt=%0d eq=%0d",
                             edge_cnt, bus.state_code, bus.gt_cnt, bus.lt_cnt, bus.eq_cnt,
                             e.edge_no, e.code, e.gt, e.lt, e.eq);
                end
            end
        end else if (bus.change_pulse !== 1'b0 ||
                     (sbq.size() > 0 && sbq[0].edge_no <= edge_cnt)) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse at edge %0d change_pulse=%b expected pulse for edge %0d",
                     edge_cnt, bus.change_pulse, (sbq.size() > 0) ? sbq[0].edge_no : -1);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
    end

    initial begin
        logic [2:0] inval[5];
        logic [2:0] f;
        int         n;
        inval[0] = 3'b000; inval[1] = 3'b011; inval[2] = 3'b101;
        inval[3] = 3'b110; inval[4] = 3'b111;

        // Reset, then eq held: first acceptance
        step(EQ, 0, 1);
        step(EQ, 0, 1);
        hold(EQ, 8);
        // Short gt glitch ignored
        hold(GT, 3);
        hold(EQ, 6);
        // eq -> gt -> lt -> gt
        hold(GT, 6);
        hold(LT, 6);
        hold(GT, 6);
        // Counter saturation
        for (int i = 0; i < 256; i++) begin
            hold(LT, STABLE);
            hold(GT, STABLE);
        end
        // clr_cnt on the lt accept edge
        hold(LT, STABLE);
        step(LT, 1);
        hold(LT, 4);
        // Non-one-hot sample, then clear the sticky flag
        step(3'b011);
        hold(LT, 6);
        step(LT, 1);
        hold(LT, 3);
        // Reset mid-filter discards progress
        hold(GT, STABLE);
        step(GT, 0, 1);
        hold(GT, 8);
        // Randomized run
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(1, 7);
            case ($urandom_range(0, 9))
                0:       f = inval[$urandom_range(0, 4)];
                1, 2, 3: f = GT;
                4, 5, 6: f = LT;
                default: f = EQ;
            endcase
            for (int j = 0; j < n; j++)
                step(f, ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
        end
        hold(EQ, 8);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
